// File: rtl/qspi_rom_reader.sv
// Quad-SPI flash read controller: sends the read command, a 24-bit address and
// dummy clocks, then streams consecutive ROM bytes to the core.
module qspi_rom_reader #(
  parameter logic [7:0] CMD           = 8'hEB,
  parameter int         DUMMY_NIBBLES = 4,
  parameter int         ADDR_W        = 24
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic              stall_read,
  output logic [7:0]        data,
  output logic              data_ready,
  output logic              busy,
  output logic              select,
  output logic              sclk,
  output logic [3:0]        cmd_addr_out,
  output logic [3:0]        cmd_addr_oe,
  input  logic [3:0]        data_in
);

  localparam int ADDR_NIBS = ADDR_W / 4;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DESELECT = 3'd1,
    CMD_S    = 3'd2,
    ADDR_S   = 3'd3,
    DUMMY_S  = 3'd4,
    DATA_S   = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic [3:0]        nib_q, nib_d;
  logic [3:0]        hi_q, hi_d;
  logic [7:0]        data_q, data_d;
  logic              ready_q, ready_d;
  logic              select_q, select_d;
  logic              sclk_q, sclk_d;
  logic [ADDR_W-1:0] addr_shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      phase_q  <= 1'b0;
      nib_q    <= '0;
      hi_q     <= '0;
      data_q   <= '0;
      ready_q  <= 1'b0;
      select_q <= 1'b1;
      sclk_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      phase_q  <= phase_d;
      nib_q    <= nib_d;
      hi_q     <= hi_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      select_q <= select_d;
      sclk_q   <= sclk_d;
    end
  end

  // In DESELECT the phase bit doubles as the two-cycle deselect counter.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    phase_d = phase_q;
    nib_d   = nib_q;
    hi_d    = hi_q;
    data_d  = data_q;
    ready_d = 1'b0;
    if (state_q == IDLE) begin
      if (restart) begin
        addr_d  = addr_in;
        state_d = CMD_S;
        phase_d = 1'b0;
        nib_d   = '0;
      end
    end else if (restart) begin
      addr_d  = addr_in;
      state_d = DESELECT;
      phase_d = 1'b0;
      nib_d   = '0;
    end else if (state_q == DESELECT) begin
      phase_d = ~phase_q;
      if (phase_q) state_d = CMD_S;
    end else if (!stall_read) begin
      phase_d = ~phase_q;
      if (phase_q) begin
        nib_d = nib_q + 4'd1;
        unique case (state_q)
          CMD_S: if (nib_q == 4'd1) begin
            state_d = ADDR_S;
            nib_d   = '0;
          end
          ADDR_S: if (nib_q == 4'(ADDR_NIBS - 1)) begin
            state_d = DUMMY_S;
            nib_d   = '0;
          end
          DUMMY_S: if (nib_q == 4'(DUMMY_NIBBLES - 1)) begin
            state_d = DATA_S;
            nib_d   = '0;
          end
          DATA_S: begin
            if (!nib_q[0]) begin
              hi_d  = data_in;
              nib_d = 4'd1;
            end else begin
              data_d  = {hi_q, data_in};
              ready_d = 1'b1;
              addr_d  = addr_q + ADDR_W'(1);
              nib_d   = '0;
            end
          end
          default: ;
        endcase
      end
    end
    select_d = (state_d == IDLE) || (state_d == DESELECT);
    sclk_d   = select_d ? 1'b0 : phase_d;
  end

  always_comb begin
    addr_shift   = addr_q >> (4 * (ADDR_NIBS - 1 - int'(nib_q)));
    cmd_addr_out = 4'h0;
    cmd_addr_oe  = 4'h0;
    if (state_q == CMD_S) begin
      cmd_addr_out = nib_q[0] ? CMD[3:0] : CMD[7:4];
      cmd_addr_oe  = 4'hF;
    end else if (state_q == ADDR_S) begin
      cmd_addr_out = addr_shift[3:0];
      cmd_addr_oe  = 4'hF;
    end
  end

  assign data       = data_q;
  assign data_ready = ready_q;
  assign busy       = (state_q != IDLE);
  assign select     = select_q;
  assign sclk       = sclk_q;

endmodule

// File: tb/tb_qspi_rom_reader.sv
// Directed bench for qspi_rom_reader with a small behavioural QSPI ROM emulator.
module tb_qspi_rom_reader;

  logic        clk;
  logic        reset;
  logic        restart;
  logic [23:0] addr_in;
  logic        stall_read;
  logic [7:0]  data;
  logic        data_ready;
  logic        busy;
  logic        select;
  logic        sclk;
  logic [3:0]  cmd_addr_out;
  logic [3:0]  cmd_addr_oe;
  logic [3:0]  data_in;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  qspi_rom_reader dut (
    .clk(clk), .reset(reset), .restart(restart), .addr_in(addr_in),
    .stall_read(stall_read), .data(data), .data_ready(data_ready), .busy(busy),
    .select(select), .sclk(sclk), .cmd_addr_out(cmd_addr_out),
    .cmd_addr_oe(cmd_addr_oe), .data_in(data_in)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] rom(input logic [23:0] a);
    case (a)
      24'h001000: rom = 8'hA5;
      24'h001001: rom = 8'h3C;
      24'h001002: rom = 8'h00;
      24'h001003: rom = 8'hFF;
      24'h000200: rom = 8'h5A;
      24'hFFFFFF: rom = 8'hC3;
      24'h000000: rom = 8'h18;
      default:    rom = a[7:0] ^ 8'h69;
    endcase
  endfunction

  // Emulator: counts sclk rising edges while selected, logs cmd/addr nibbles, serves data.
  int          emu_cnt = 0;
  logic [23:0] emu_addr = '0;
  logic [7:0]  emu_byte;
  logic [3:0]  nib_log [16];
  logic [3:0]  oe_log  [16];

  initial data_in = 4'h0;
  always @(posedge select) emu_cnt = 0;
  always @(posedge sclk) begin
    if (!select) begin
      if (emu_cnt < 16) begin
        nib_log[emu_cnt] = cmd_addr_out;
        oe_log[emu_cnt]  = cmd_addr_oe;
      end
      if (emu_cnt >= 2 && emu_cnt < 8) emu_addr = {emu_addr[19:0], cmd_addr_out};
      if (emu_cnt >= 12) begin
        emu_byte = rom(emu_addr + 24'((emu_cnt - 12) >> 1));
        data_in  = ((emu_cnt - 12) % 2 == 0) ? emu_byte[7:4] : emu_byte[3:0];
      end else begin
        data_in = 4'h0;
      end
      emu_cnt++;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic waitReady(input int limit);
    do step(); while (!data_ready && cyc < limit);
  endtask

  task automatic applyStimulus(input logic [23:0] a);
    restart = 1'b1;
    addr_in = a;
    cyc     = 0;
    step();
    restart = 1'b0;
  endtask

  task automatic pulseReset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
  endtask

  task automatic checkNibbles(input string tag, input logic [31:0] exp);
    logic [31:0] got;
    logic [7:0]  oes;
    logic [3:0]  dum;
    for (int i = 0; i < 8; i++) begin
      got[31-4*i -: 4] = nib_log[i];
      oes[7-i]         = &oe_log[i];
    end
    for (int i = 0; i < 4; i++) dum[i] = |oe_log[8+i];
    checkOutput({tag, "_nibbles"}, got, exp);
    checkOutput({tag, "_oe_cmdaddr"}, {24'h0, oes}, 32'hFF);
    checkOutput({tag, "_oe_dummy"}, {28'h0, dum}, 32'h0);
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; addr_in = '0; stall_read = 1'b0;
    #2;
    checkOutput("reset_select", select, 1);
    checkOutput("reset_sclk", sclk, 0);
    checkOutput("reset_oe", cmd_addr_oe, 0);
    checkOutput("reset_out", cmd_addr_out, 0);
    checkOutput("reset_data", data, 0);
    checkOutput("reset_ready", data_ready, 0);
    checkOutput("reset_busy", busy, 0);
    step();
    reset = 1'b0;
    step();

    // Basic read from 0x1000 and streaming
    applyStimulus(24'h001000);
    checkOutput("t1_busy", busy, 1);
    checkOutput("t1_select", select, 0);
    waitReady(100);
    checkOutput("t1_first_cycle", cyc, 29);
    checkOutput("t1_first_data", data, 8'hA5);
    checkNibbles("t1", 32'hEB001000);
    step();
    checkOutput("t1_pulse_width", data_ready, 0);
    waitReady(100);
    checkOutput("t1_b1_cycle", cyc, 33);
    checkOutput("t1_b1_data", data, 8'h3C);
    step();
    checkOutput("t1_b1_width", data_ready, 0);
    waitReady(100);
    checkOutput("t1_b2_cycle", cyc, 37);
    checkOutput("t1_b2_data", data, 8'h00);
    waitReady(100);
    checkOutput("t1_b3_cycle", cyc, 41);
    checkOutput("t1_b3_data", data, 8'hFF);

    // Asynchronous reset in the middle of DATA
    step();
    reset = 1'b1;
    #2;
    checkOutput("arst_select", select, 1);
    checkOutput("arst_sclk", sclk, 0);
    checkOutput("arst_oe", cmd_addr_oe, 0);
    checkOutput("arst_ready", data_ready, 0);
    checkOutput("arst_busy", busy, 0);
    step();
    reset = 1'b0;
    step();

    // Stall for 7 cycles starting at cycle 31
    applyStimulus(24'h001000);
    waitReady(100);
    checkOutput("t3_first_cycle", cyc, 29);
    step(); step();
    stall_read = 1'b1;
    checkOutput("t3_sclk_start", sclk, 0);
    for (int i = 0; i < 7; i++) begin
      checkOutput("t3_sclk_frozen", sclk, 0);
      checkOutput("t3_select_low", select, 0);
      checkOutput("t3_no_ready", data_ready, 0);
      step();
    end
    stall_read = 1'b0;
    waitReady(100);
    checkOutput("t3_ready_cycle", cyc, 40);
    checkOutput("t3_data", data, 8'h3C);

    // Restart while streaming
    pulseReset();
    applyStimulus(24'h001000);
    waitReady(100);
    waitReady(100);
    checkOutput("t4_pre_cycle", cyc, 33);
    step(); step();
    restart = 1'b1;
    addr_in = 24'h000200;
    step();
    restart = 1'b0;
    checkOutput("t4_desel1_select", select, 1);
    checkOutput("t4_desel1_sclk", sclk, 0);
    checkOutput("t4_desel1_busy", busy, 1);
    checkOutput("t4_desel1_data", data, 8'h3C);
    step();
    checkOutput("t4_desel2_select", select, 1);
    checkOutput("t4_desel2_sclk", sclk, 0);
    step();
    checkOutput("t4_cmd_select", select, 0);
    waitReady(200);
    checkOutput("t4_first_cycle", cyc, 66);
    checkOutput("t4_first_data", data, 8'h5A);
    checkNibbles("t4", 32'hEB000200);

    // Address wrap-around
    step();
    applyStimulus(24'hFFFFFF);
    waitReady(100);
    checkOutput("t5_first_cycle", cyc, 31);
    checkOutput("t5_first_data", data, 8'hC3);
    waitReady(100);
    checkOutput("t5_wrap_cycle", cyc, 35);
    checkOutput("t5_wrap_data", data, 8'h18);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/qspi_rom_reader.md
Name: qspi_rom_reader

Overview:
- QSPI flash read controller that supplies cartridge ROM bytes to the Atari 2600 core.
- Issues a quad-lane read command, a 24-bit address and dummy cycles, then streams consecutive bytes to the core.
- Sits between the core's ROM fetch logic (upstream) and the external flash, or the testbench QSPI ROM emulator, on the uio pins (downstream).
- Sequential streaming; any new address requires a restart.

Parameters:
- CMD, 8'hEB: read command byte, sent as two nibbles, high nibble first.
- DUMMY_NIBBLES, 4: number of sclk periods between the last address nibble and the first data nibble.
- ADDR_W, 24: flash address width.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- restart  in  1  one-cycle pulse; start a new read at addr_in
- addr_in  in  24  start address, sampled when restart=1
- stall_read  in  1  freeze the transfer while high
- data  out  8  last received byte
- data_ready  out  1  one-cycle pulse; data is valid
- busy  out  1  high whenever state != IDLE
- select  out  1  flash chip select, active low
- sclk  out  1  flash clock, clk/2
- cmd_addr_out  out  4  nibble driven to flash, {io3..io0}
- cmd_addr_oe  out  4  output enables for cmd_addr_out; all 1 or all 0
- data_in  in  4  nibble from flash

Behaviour:
- Reset (async): state=IDLE, select=1, sclk=0, cmd_addr_out=0, cmd_addr_oe=0, data=0, data_ready=0, addr counter=0, phase=0, nibble count=0.
- State register is 3 bits. States: IDLE, DESELECT, CMD, ADDR, DUMMY, DATA.
- Nibble timing (every nibble takes 2 clk):
  - phase 0: sclk=0; a new output nibble is driven on cmd_addr_out.
  - phase 1: sclk=1; on the clk edge ending phase 1, data_in is sampled (DUMMY/DATA only) and the counters advance.
- IDLE: select=1, sclk=0.
  - restart=1: latch addr_in, select=0 on the next cycle, go to CMD.
- CMD: 2 nibbles, CMD[7:4] then CMD[3:0]; cmd_addr_oe=4'hF. Then go to ADDR.
- ADDR: 6 nibbles, addr[23:20] first down to addr[3:0]; cmd_addr_oe=4'hF. Then go to DUMMY.
- DUMMY: DUMMY_NIBBLES sclk periods, cmd_addr_oe=0, data_in ignored. Then go to DATA.
- DATA: cmd_addr_oe=0.
  - First sampled nibble of each pair is data[7:4], second is data[3:0].
  - After the second nibble: data updates and data_ready pulses for exactly 1 cycle (the cycle after that edge). addr increments by 1, wrapping from 2^ADDR_W-1 to 0.
  - DATA repeats indefinitely: one byte every 4 clk.
- Latency: restart on cycle 0 → first data_ready on cycle 21+2*DUMMY_NIBBLES (29 at default); subsequent bytes every 4 cycles.
- stall_read=1 in CMD/ADDR/DUMMY/DATA:
  - sclk, phase, counters and outputs hold their values; select stays 0.
  - If stall begins while sclk=1, sclk stays 1; no sample is taken and no edge is produced.
  - Resumes on the cycle after stall_read falls; no nibble is lost or duplicated.
  - stall_read has no effect in IDLE/DESELECT.
- restart while busy (any state except IDLE):
  - Abort, latch addr_in, go to DESELECT: select=1, sclk=0 for 2 cycles, then select=0 and go to CMD.
  - A pending data_ready in that cycle is suppressed.
- restart has priority over stall_read. restart during DESELECT re-latches addr_in and restarts the 2-cycle count.
- data holds its last value outside DATA. data_ready is never asserted outside DATA.

Test Plan:
- Reset mid-DATA (assert reset) → select=1, sclk=0, cmd_addr_oe=0, data_ready=0, busy=0 within the same cycle, with no clock required.
- restart with addr_in=24'h001000, emulator byte 0x1000=8'hA5 → cmd_addr_out nibbles E,B,0,0,1,0,0,0 on successive sclk rising edges with oe=F; oe=0 for 4 sclk periods; data_ready on cycle 29 with data=8'hA5.
- Continue streaming with emulator bytes 0x1001..0x1003 = 3C,00,FF → data_ready pulses on cycles 33, 37, 41 with data 3C, 00, FF; every pulse is 1 cycle wide.
- stall_read high for 7 cycles starting at cycle 31 → sclk frozen at its current level and select=0 throughout; next data_ready moves from cycle 33 to 40 with the correct byte.
- restart to 24'h000200 at cycle 35 → select=1 for exactly 2 cycles, sclk=0; nibbles E,B,0,0,0,2,0,0 follow; first byte from 0x200 delivered 29+2 cycles after the restart.
- restart at 24'hFFFFFF → bytes from FFFFFF then 000000 delivered back-to-back, 4 cycles apart.
